dpdm_decode: RTL

DPDM_DECODE -- requirements
Module: dpdm_decode

---
 rtl/usb_pkg.sv | 42 ++++
 rtl/dpdm_timeout_counter.sv | 47 ++++
 rtl/dpdm_decode.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/usb_pkg.sv
// ============================================================================
// Package : usb_pkg
// Brief   : Line-symbol and decoder-state types shared by the DP/DM decoder.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package usb_pkg;

    typedef enum logic [1:0] {
        SYM_J   = 2'd0,
        SYM_K   = 2'd1,
        SYM_SE0 = 2'd2,
        SYM_SE1 = 2'd3
    } sym_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_PACKET = 3'd2,
        ST_EOP_1  = 3'd3,
        ST_EOP_2  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    // SYNC as decoded bits, LSB is the first symbol on the wire (K=0, J=1)
    localparam logic [7:0] SYNC_PATTERN = 8'b0010_1010;
    localparam int         BIT_COUNT_W  = 11;

    function automatic sym_e decode_sym(input logic dp, input logic dm);
        case ({dp, dm})
            2'b10:   decode_sym = SYM_J;
            2'b01:   decode_sym = SYM_K;
            2'b00:   decode_sym = SYM_SE0;
            default: decode_sym = SYM_SE1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/dpdm_timeout_counter.sv
// ============================================================================
// Module : dpdm_timeout_counter
// Brief  : Idle-cycle counter; flags the increment that completes the window.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dpdm_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic expired_o
);

    localparam int                CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Depends only on the count so the caller can gate it with its own inc
    // without forming a combinational loop through this block.
    assign expired_o = (count_q == LAST_COUNT);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i) begin
            count_d = expired_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dpdm_decode.sv
// ============================================================================
// Module : dpdm_decode
// Brief  : DP/DM line-symbol decoder: SYNC strip, payload bits, EOP detect.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module dpdm_decode
    import usb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   DP,
    input  logic                   DM,
    input  logic                   rx_enable,
    output logic                   out_bit,
    output logic                   out_valid,
    output logic                   receiving,
    output logic                   eop_seen,
    output logic                   rx_error,
    output logic                   timeout,
    output logic [BIT_COUNT_W-1:0] bit_count
);

    state_e                 state_q, state_d;
    logic [2:0]             idx_q, idx_d;
    logic                   out_bit_q, out_bit_d;
    logic                   out_valid_q, out_valid_d;
    logic                   receiving_q, receiving_d;
    logic                   eop_q, eop_d;
    logic                   err_q, err_d;
    logic                   tmo_q, tmo_d;
    logic [BIT_COUNT_W-1:0] bc_q, bc_d;

    sym_e sym;
    logic sym_bit;
    logic sym_data;
    logic go_error;
    logic tmo_inc;
    logic tmo_clr;
    logic tmo_expired;

    dpdm_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock     (clock),
        .reset_n   (reset_n),
        .inc_i     (tmo_inc),
        .clr_i     (tmo_clr),
        .expired_o (tmo_expired)
    );

    always_comb begin
        sym         = decode_sym(DP, DM);
        sym_bit     = (sym == SYM_J);
        sym_data    = (sym == SYM_J) || (sym == SYM_K);
        state_d     = state_q;
        idx_d       = idx_q;
        out_bit_d   = out_bit_q;
        out_valid_d = 1'b0;
        receiving_d = receiving_q;
        eop_d       = 1'b0;
        err_d       = 1'b0;
        tmo_d       = 1'b0;
        bc_d        = bc_q;
        go_error    = 1'b0;
        tmo_inc     = 1'b0;
        tmo_clr     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_enable) begin
                    tmo_clr = 1'b1;
                end else if (sym == SYM_K) begin
                    state_d     = ST_SYNC;
                    idx_d       = 3'd1;
                    bc_d        = '0;
                    receiving_d = 1'b1;
                    tmo_clr     = 1'b1;
                end else begin
                    tmo_inc = 1'b1;
                    tmo_d   = tmo_expired;
                end
            end
            ST_SYNC, ST_PACKET, ST_EOP_1, ST_EOP_2: begin
                if (!rx_enable) begin
                    state_d     = ST_IDLE;
                    idx_d       = '0;
                    receiving_d = 1'b0;
                end else if (sym == SYM_SE1) begin
                    go_error = 1'b1;
                end else begin
                    case (state_q)
                        ST_SYNC: begin
                            if (sym_data && (sym_bit == SYNC_PATTERN[idx_q])) begin
                                if (idx_q == 3'd7) begin
                                    state_d = ST_PACKET;
                                    idx_d   = '0;
                                end else begin
                                    idx_d = idx_q + 3'd1;
                                end
                            end else begin
                                go_error = 1'b1;
                            end
                        end
                        ST_PACKET: begin
                            if (sym_data) begin
                                out_bit_d   = sym_bit;
                                out_valid_d = 1'b1;
                                if (bc_q != {BIT_COUNT_W{1'b1}}) begin
                                    bc_d = bc_q + 1'b1;
                                end
                            end else begin
                                state_d = ST_EOP_1;
                            end
                        end
                        ST_EOP_1: begin
                            if (sym == SYM_SE0) state_d = ST_EOP_2;
                            else                go_error = 1'b1;
                        end
                        default: begin
                            if (sym == SYM_J) begin
                                state_d     = ST_DONE;
                                eop_d       = 1'b1;
                                receiving_d = 1'b0;
                            end else begin
                                go_error = 1'b1;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (go_error) begin
            state_d     = ST_ERROR;
            idx_d       = '0;
            err_d       = 1'b1;
            receiving_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            out_bit_q   <= 1'b0;
            out_valid_q <= 1'b0;
            receiving_q <= 1'b0;
            eop_q       <= 1'b0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
            bc_q        <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_bit_q   <= out_bit_d;
            out_valid_q <= out_valid_d;
            receiving_q <= receiving_d;
            eop_q       <= eop_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
            bc_q        <= bc_d;
        end
    end

    assign out_bit   = out_bit_q;
    assign out_valid = out_valid_q;
    assign receiving = receiving_q;
    assign eop_seen  = eop_q;
    assign rx_error  = err_q;
    assign timeout   = tmo_q;
    assign bit_count = bc_q;

endmodule

`default_nettype wire
